// File: rtl/biquad_seq_pkg.sv
// biquad_seq_pkg: select codes shared between the biquad MAC datapath mux and
// its sequencer, plus the fixed-point format of the datapath.
// Optional feature macro used by this slice: BIQUAD_OVERRUN_EN.
package biquad_seq_pkg;

  // Datapath word width and fractional bits (coefficients are Q(N-F).F).
  localparam int N = 16;
  localparam int F = 14;

  // Width of the per-step cycle counter; covers STEP_CYCLES up to 15.
  localparam int STEP_CW = 4;

  // Coefficient select (controlS).
  localparam logic [2:0] SEL_S_ZERO = 3'd0;
  localparam logic [2:0] SEL_S_A1   = 3'd1;
  localparam logic [2:0] SEL_S_A2   = 3'd2;
  localparam logic [2:0] SEL_S_B0   = 3'd3;
  localparam logic [2:0] SEL_S_B1   = 3'd4;
  localparam logic [2:0] SEL_S_B2   = 3'd5;

  // State select (controlC).
  localparam logic [1:0] SEL_C_ZERO = 2'd0;
  localparam logic [1:0] SEL_C_FK1  = 2'd1;
  localparam logic [1:0] SEL_C_FK2  = 2'd2;
  localparam logic [1:0] SEL_C_FK   = 2'd3;

  // Additive-term select (controlZ).
  localparam logic [1:0] SEL_Z_ZERO = 2'd0;
  localparam logic [1:0] SEL_Z_UK   = 2'd1;
  localparam logic [1:0] SEL_Z_YK   = 2'd2;

  // One mux setting for the datapath.
  typedef struct packed {
    logic [2:0] s;
    logic [1:0] c;
    logic [1:0] z;
  } sel_t;

  localparam sel_t SEL_NONE = '{s: SEL_S_ZERO, c: SEL_C_ZERO, z: SEL_Z_ZERO};

endpackage

// File: rtl/biquad_seq_step_timer.sv
// step_timer: counts 0..STEP_CYCLES-1 within one sequencer state. clr forces
// the count back to 0 (used on every state change). 'last' flags the final
// cycle of the current step; 'last_next' is the value 'last' will take after
// the coming edge, so the sequencer can register its load strobes.
module step_timer
  import biquad_seq_pkg::*;
#(
  parameter int STEP_CYCLES = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  output logic last,
  output logic last_next
);

  localparam logic [STEP_CW-1:0] LAST_VAL = STEP_CW'(STEP_CYCLES - 1);

  logic [STEP_CW-1:0] r_count;
  logic [STEP_CW-1:0] w_count_next;

  // Next count: restart on clr, otherwise wrap after the last cycle.
  always_comb begin
    w_count_next = r_count + STEP_CW'(1);
    if (clr || (r_count == LAST_VAL)) begin
      w_count_next = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else begin
      r_count <= w_count_next;
    end
  end

  assign last      = (r_count == LAST_VAL);
  assign last_next = (w_count_next == LAST_VAL);

endmodule

// File: rtl/biquad_seq.sv
// biquad_seq: sequencer for the Direct-Form-II biquad MAC datapath. One start
// pulse walks A1 -> A2 -> B0 -> B1 -> B2 -> SHIFT, each MAC step held for
// STEP_CYCLES cycles with its load strobe in the step's final cycle.
// Every output is a flop, decoded from the next state one edge ahead.
// Optional macro BIQUAD_OVERRUN_EN adds a sticky 'overrun' flag for starts
// that arrive while busy.
module biquad_seq
  import biquad_seq_pkg::*;
#(
  parameter int STEP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start,
  output logic       ready,
  output logic [2:0] controlS,
  output logic [1:0] controlC,
  output logic [1:0] controlZ,
  output logic       en_yk,
  output logic       en_fk,
  output logic       shift,
  output logic       done
`ifdef BIQUAD_OVERRUN_EN
  ,
  output logic       overrun
`endif
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_A1    = 3'd1,
    ST_A2    = 3'd2,
    ST_B0    = 3'd3,
    ST_B1    = 3'd4,
    ST_B2    = 3'd5,
    ST_SHIFT = 3'd6
  } state_e;

  state_e r_state, w_state_next;
  logic   w_last, w_last_next, w_clr;

  sel_t   r_sel, w_sel_next;
  logic   r_ready, r_en_yk, r_en_fk, r_shift, r_done;
  logic   w_ready_next, w_en_yk_next, w_en_fk_next, w_shift_next, w_done_next;

  assign w_clr = (w_state_next != r_state);

  step_timer #(
    .STEP_CYCLES(STEP_CYCLES)
  ) u_step_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .clr      (w_clr),
    .last     (w_last),
    .last_next(w_last_next)
  );

  // Next state: leave a MAC step only in its last cycle; start only from IDLE.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE:  if (start)  w_state_next = ST_A1;
      ST_A1:    if (w_last) w_state_next = ST_A2;
      ST_A2:    if (w_last) w_state_next = ST_B0;
      ST_B0:    if (w_last) w_state_next = ST_B1;
      ST_B1:    if (w_last) w_state_next = ST_B2;
      ST_B2:    if (w_last) w_state_next = ST_SHIFT;
      ST_SHIFT: w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Output decode of the state being entered; strobes gated by its last cycle.
  always_comb begin
    w_sel_next   = SEL_NONE;
    w_ready_next = 1'b0;
    w_en_yk_next = 1'b0;
    w_en_fk_next = 1'b0;
    w_shift_next = 1'b0;
    w_done_next  = 1'b0;
    case (w_state_next)
      ST_IDLE: w_ready_next = 1'b1;
      ST_A1: begin
        w_sel_next   = '{s: SEL_S_A1, c: SEL_C_FK1, z: SEL_Z_UK};
        w_en_yk_next = w_last_next;
      end
      ST_A2: begin
        w_sel_next   = '{s: SEL_S_A2, c: SEL_C_FK2, z: SEL_Z_YK};
        w_en_fk_next = w_last_next;
      end
      ST_B0: begin
        w_sel_next   = '{s: SEL_S_B0, c: SEL_C_FK, z: SEL_Z_ZERO};
        w_en_yk_next = w_last_next;
      end
      ST_B1: begin
        w_sel_next   = '{s: SEL_S_B1, c: SEL_C_FK1, z: SEL_Z_YK};
        w_en_yk_next = w_last_next;
      end
      ST_B2: begin
        w_sel_next   = '{s: SEL_S_B2, c: SEL_C_FK2, z: SEL_Z_YK};
        w_en_yk_next = w_last_next;
      end
      ST_SHIFT: begin
        w_shift_next = 1'b1;
        w_done_next  = 1'b1;
      end
      default: w_ready_next = 1'b0;
    endcase
  end

  // State and registered outputs; reset lands everything in the IDLE picture.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_sel   <= SEL_NONE;
      r_ready <= 1'b1;
      r_en_yk <= 1'b0;
      r_en_fk <= 1'b0;
      r_shift <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sel   <= w_sel_next;
      r_ready <= w_ready_next;
      r_en_yk <= w_en_yk_next;
      r_en_fk <= w_en_fk_next;
      r_shift <= w_shift_next;
      r_done  <= w_done_next;
    end
  end

  assign ready    = r_ready;
  assign controlS = r_sel.s;
  assign controlC = r_sel.c;
  assign controlZ = r_sel.z;
  assign en_yk    = r_en_yk;
  assign en_fk    = r_en_fk;
  assign shift    = r_shift;
  assign done     = r_done;

`ifdef BIQUAD_OVERRUN_EN
  logic r_overrun;

  // Sticky flag: any start seen while busy; never disturbs the running sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_overrun <= 1'b0;
    end else if (start && !r_ready) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`endif

endmodule

// File: tb/tb_biquad_seq.sv
// tb_biquad_seq: two sequencers (STEP_CYCLES=1 and 3) checked every cycle
// against a schedule model derived from the per-step select table, plus
// directed corner sequences and a closed loop through a behavioural datapath.
module tb_biquad_seq;

  localparam int F  = 14;
  localparam int A1 = -26066;
  localparam int A2 = -10841;
  localparam int B0 = 13323;
  localparam int B1 = 26640;
  localparam int B2 = 13323;
  localparam logic [11:0] RESET_VEC = 12'h800;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic start1 = 1'b0;
  logic start3 = 1'b0;

  logic       ready1, ready3, eyk1, eyk3, efk1, efk3, sh1, sh3, dn1, dn3;
  logic [2:0] cs1, cs3;
  logic [1:0] cc1, cc3, cz1, cz3;
`ifdef BIQUAD_OVERRUN_EN
  logic ovr1, ovr3;
  bit   ov1_exp = 1'b0;
  bit   ov3_exp = 1'b0;
`endif

  always #5 clk = ~clk;

  biquad_seq #(.STEP_CYCLES(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start1), .ready(ready1),
    .controlS(cs1), .controlC(cc1), .controlZ(cz1),
    .en_yk(eyk1), .en_fk(efk1), .shift(sh1), .done(dn1)
`ifdef BIQUAD_OVERRUN_EN
    , .overrun(ovr1)
`endif
  );

  biquad_seq #(.STEP_CYCLES(3)) dut3 (
    .clk(clk), .reset_n(reset_n), .start(start3), .ready(ready3),
    .controlS(cs3), .controlC(cc3), .controlZ(cz3),
    .en_yk(eyk3), .en_fk(efk3), .shift(sh3), .done(dn3)
`ifdef BIQUAD_OVERRUN_EN
    , .overrun(ovr3)
`endif
  );

  // Output bundles: {ready, S, C, Z, en_yk, en_fk, shift, done}
  logic [11:0] vec1, vec3;
  assign vec1 = {ready1, cs1, cc1, cz1, eyk1, efk1, sh1, dn1};
  assign vec3 = {ready3, cs3, cc3, cz3, eyk3, efk3, sh3, dn3};

  // The per-step table: selects and which register the step loads.
  typedef struct {
    int s;
    int c;
    int z;
    bit yk;
    bit fk;
  } step_t;
  step_t steps[5];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int s1       = -1000;  // cycle of the last accepted start, dut1
  int s3       = -1000;  // same for dut3

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Expected outputs in cycle c for a sample started in cycle s.
  function automatic logic [11:0] exp_vec(input int c, input int s, input int sc);
    logic [11:0] v;
    int t, k, ph;
    v = RESET_VEC;
    t = c - s;
    if (t >= 1 && t <= 5 * sc) begin
      k  = (t - 1) / sc;
      ph = (t - 1) % sc;
      v[11]   = 1'b0;
      v[10:8] = 3'(steps[k].s);
      v[7:6]  = 2'(steps[k].c);
      v[5:4]  = 2'(steps[k].z);
      v[3]    = steps[k].yk && (ph == sc - 1);
      v[2]    = steps[k].fk && (ph == sc - 1);
    end else if (t == 5 * sc + 1) begin
      v = 12'h003;
    end
    return v;
  endfunction

  // One cycle: check this cycle's outputs, then drive start for it.
  task automatic tick(input bit st1, input bit st3);
    logic [11:0] e1, e3;
    @(negedge clk);
    cyc++;
    e1 = exp_vec(cyc, s1, 1);
    e3 = exp_vec(cyc, s3, 3);
    check("outs_sc1", {20'd0, vec1}, {20'd0, e1});
    check("outs_sc3", {20'd0, vec3}, {20'd0, e3});
`ifdef BIQUAD_OVERRUN_EN
    check("overrun_sc1", {31'd0, ovr1}, {31'd0, ov1_exp});
    check("overrun_sc3", {31'd0, ovr3}, {31'd0, ov3_exp});
    if (st1 && !e1[11]) ov1_exp = 1'b1;
    if (st3 && !e3[11]) ov3_exp = 1'b1;
`endif
    if (st1 && e1[11]) s1 = cyc;
    if (st3 && e3[11]) s3 = cyc;
    start1 = st1;
    start3 = st3;
  endtask

  // Behavioural datapath driven by dut1's selects.
  int dp_yk, dp_fk, dp_fk1, dp_fk2;
  int uk = 0;

  function automatic int dp_mac(input logic [2:0] s, input logic [1:0] c, input logic [1:0] z,
                                input int u, input int y, input int f, input int f1, input int f2);
    int coef, st, ad;
    case (s)
      3'd1: coef = A1;
      3'd2: coef = A2;
      3'd3: coef = B0;
      3'd4: coef = B1;
      3'd5: coef = B2;
      default: coef = 0;
    endcase
    case (c)
      2'd1: st = f1;
      2'd2: st = f2;
      2'd3: st = f;
      default: st = 0;
    endcase
    case (z)
      2'd1: ad = u;
      2'd2: ad = y;
      default: ad = 0;
    endcase
    return ad + ((coef * st) >>> F);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_yk  <= 0;
      dp_fk  <= 0;
      dp_fk1 <= 0;
      dp_fk2 <= 0;
    end else begin
      if (eyk1) dp_yk <= dp_mac(cs1, cc1, cz1, uk, dp_yk, dp_fk, dp_fk1, dp_fk2);
      if (efk1) dp_fk <= dp_mac(cs1, cc1, cz1, uk, dp_yk, dp_fk, dp_fk1, dp_fk2);
      if (sh1) begin
        dp_fk2 <= dp_fk1;
        dp_fk1 <= dp_fk;
      end
    end
  end

  initial begin
    int base, d3, sh_cnt, dn_cnt, g1, g2, gf, gy, want;
    int dones[$];

    steps[0] = '{s: 1, c: 1, z: 1, yk: 1'b1, fk: 1'b0};
    steps[1] = '{s: 2, c: 2, z: 2, yk: 1'b0, fk: 1'b1};
    steps[2] = '{s: 3, c: 3, z: 0, yk: 1'b1, fk: 1'b0};
    steps[3] = '{s: 4, c: 1, z: 2, yk: 1'b1, fk: 1'b0};
    steps[4] = '{s: 5, c: 2, z: 2, yk: 1'b1, fk: 1'b0};

    // Reset values while held in reset.
    repeat (3) @(negedge clk);
    check("reset_sc1", {20'd0, vec1}, {20'd0, RESET_VEC});
    check("reset_sc3", {20'd0, vec3}, {20'd0, RESET_VEC});
    reset_n = 1'b1;
    repeat (3) tick(1'b0, 1'b0);

    // Directed: ignored start at +3, back-to-back at +7, start during done at +13.
    base = cyc + 1;
    d3 = -1;
    sh_cnt = 0;
    for (int r = 0; r < 20; r++) begin
      tick(r == 0 || r == 3 || r == 7 || r == 13, r == 0);
`ifdef BIQUAD_OVERRUN_EN
      if (r == 3) check("overrun_clear_at_3", {31'd0, ovr1}, 32'd0);
      if (r == 4) check("overrun_set_at_4", {31'd0, ovr1}, 32'd1);
`endif
      if (dn1) dones.push_back(cyc - base);
      if (sh1) sh_cnt++;
      if (dn3) d3 = cyc - base;
    end
    check("done_count_sc1", dones.size(), 32'd2);
    if (dones.size() == 2) begin
      check("done0_cycle_sc1", dones[0], 32'd6);
      check("done1_cycle_sc1", dones[1], 32'd13);
    end
    check("shift_count_sc1", sh_cnt, 32'd2);
    check("done_cycle_sc3", d3, 32'd16);

    // Reset in cycle 3 of a sample: outputs drop at once, no done afterwards.
    tick(1'b1, 1'b1);
    repeat (3) tick(1'b0, 1'b0);
    reset_n = 1'b0;
    #1;
    check("midreset_sc1", {20'd0, vec1}, {20'd0, RESET_VEC});
    check("midreset_sc3", {20'd0, vec3}, {20'd0, RESET_VEC});
    s1 = -1000;
    s3 = -1000;
`ifdef BIQUAD_OVERRUN_EN
    ov1_exp = 1'b0;
    ov3_exp = 1'b0;
`endif
    tick(1'b0, 1'b0);
    reset_n = 1'b1;
    dn_cnt = 0;
    for (int r = 0; r < 20; r++) begin
      tick(1'b0, 1'b0);
      if (dn1 || dn3) dn_cnt++;
    end
    check("no_done_after_reset", dn_cnt, 32'd0);
    check("ready_after_reset", {31'd0, ready1}, 32'd1);

    // Closed loop: constant input through datapath versus the DF-II equations.
    uk = 8000;
    g1 = 0;
    g2 = 0;
    gy = 0;
    for (int n = 0; n < 60; n++) begin
      tick(1'b1, 1'b0);
      repeat (6) tick(1'b0, 1'b0);
      gf = uk + ((A1 * g1) >>> F) + ((A2 * g2) >>> F);
      gy = ((B0 * gf) >>> F) + ((B1 * g1) >>> F) + ((B2 * g2) >>> F);
      g2 = g1;
      g1 = gf;
      check("loop_done", {31'd0, dn1}, 32'd1);
      if (dp_yk - gy > 1 || gy - dp_yk > 1) check("loop_yk", dp_yk, gy);
      else check("loop_yk", 32'd0, 32'd0 + ((dp_yk == dp_yk) ? 0 : 1));
    end
    want = (uk * 53286 + 53291 / 2) / 53291;
    n_checks++;
    if (dp_yk - want > 8 || want - dp_yk > 8) begin
      n_fail++;
      $display("FAIL dc_gain: yk=%0d, expected about %0d", dp_yk, want);
    end

    // Random start traffic against the schedule model.
    for (int r = 0; r < 800; r++) begin
      tick($urandom_range(0, 5) == 0, $urandom_range(0, 7) == 0);
    end
    repeat (20) tick(1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
